// File: rtl/piso_serializer_pkg.sv
// ============================================================================
// piso_serializer_pkg : shared state encoding for the serial TX/RX blocks
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package piso_serializer_pkg;

    // Receivers and serializers import this so both ends agree on the encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : piso_serializer_pkg

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// piso_serializer : valid/ready parallel-in, serial-out transmitter with frame/last
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int   WIDTH     = 4,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_LVL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_par,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             frame,
    output logic             last,
    output logic             busy
);

    localparam int                CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [WIDTH-1:0]   shreg_shifted;
    logic               out_bit;
    logic               accept;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
            assign out_bit       = shreg_q[WIDTH-1];
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
            assign out_bit       = shreg_q[0];
        end
    endgenerate

    // Ready during the last bit is what makes back-to-back words gapless.
    assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == '0));
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shreg_d = din_par;
            cnt_d   = CNT_MAX;
        end else if (state_q == SHIFT) begin
            shreg_d = shreg_shifted;
            if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == SHIFT);
    assign dout  = busy ? out_bit : IDLE_LVL;
    assign frame = busy && (cnt_q == CNT_MAX);
    assign last  = busy && (cnt_q == '0);

endmodule : piso_serializer

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ============================================================================
// tb_piso_serializer : random + directed check of two serializer configurations
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_piso_serializer;

    typedef bit bitq_t[$];

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] din4;
    logic       v4, rdy4, dout4, frame4, last4, busy4;
    logic [7:0] din8;
    logic       v8, rdy8, dout8, frame8, last8, busy8;

    int         n_tests = 0;
    int         n_fail  = 0;
    bitq_t      q4, q8;
    logic [15:0] obs4, obs8;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LVL(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .din_par(din4), .load_valid(v4), .load_ready(rdy4),
        .dout(dout4), .frame(frame4), .last(last4), .busy(busy4)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LVL(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .din_par(din8), .load_valid(v8), .load_ready(rdy8),
        .dout(dout8), .frame(frame8), .last(last8), .busy(busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: the in-flight word is just the queue of bits still to appear on dout.
    function automatic bitq_t model_next(bitq_t q, int w, bit msb, logic v, logic [7:0] d);
        bitq_t r = q;
        bit    rdy = (r.size() <= 1);
        if (v && rdy) begin
            r = {};
            for (int i = 0; i < w; i++) r.push_back(msb ? d[w-1-i] : d[i]);
        end else if (r.size() > 0) begin
            void'(r.pop_front());
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("w4_busy",  32'(busy4),  32'(q4.size() > 0));
        check("w4_dout",  32'(dout4),  32'((q4.size() > 0) ? q4[0] : 1'b0));
        check("w4_frame", 32'(frame4), 32'(q4.size() == 4));
        check("w4_last",  32'(last4),  32'(q4.size() == 1));
        check("w4_ready", 32'(rdy4),   32'(q4.size() <= 1));
        check("w8_busy",  32'(busy8),  32'(q8.size() > 0));
        check("w8_dout",  32'(dout8),  32'((q8.size() > 0) ? q8[0] : 1'b1));
        check("w8_frame", 32'(frame8), 32'(q8.size() == 8));
        check("w8_last",  32'(last8),  32'(q8.size() == 1));
        check("w8_ready", 32'(rdy8),   32'(q8.size() <= 1));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic a_v, input logic [3:0] a_d,
                         input logic b_v, input logic [7:0] b_d);
        v4 = a_v; din4 = a_d; v8 = b_v; din8 = b_d;
        #1;
        check_outputs();
        obs4 = {obs4[14:0], dout4};
        obs8 = {obs8[14:0], dout8};
        @(posedge clk);
        q4 = model_next(q4, 4, 1'b1, a_v, {4'b0, a_d});
        q8 = model_next(q8, 8, 1'b0, b_v, b_d);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a word offered: nothing may be accepted.
        rst = 1'b1; v4 = 1'b1; din4 = 4'hF; v8 = 1'b1; din8 = 8'hFF;
        obs4 = '0; obs8 = '0;
        #1;
        check_outputs();
        repeat (2) begin
            @(posedge clk); #1;
            check_outputs();
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Single word, MSB first.
        cycle(1'b1, 4'b1011, 1'b0, 8'h00);
        idle_cycles(4);
        check("single_word_bits", 32'(obs4[3:0]), 32'h0000000B);
        idle_cycles(2);

        // Back-to-back with load_valid held through the first word.
        cycle(1'b1, 4'b1011, 1'b0, 8'h00);
        repeat (4) cycle(1'b1, 4'b0110, 1'b0, 8'h00);
        idle_cycles(4);
        check("back_to_back_bits", 32'(obs4[7:0]), 32'h000000B6);
        idle_cycles(2);

        // Hold-off: second word offered from bit 2 onward.
        cycle(1'b1, 4'hA, 1'b0, 8'h00);
        cycle(1'b0, 4'h0, 1'b0, 8'h00);
        repeat (3) cycle(1'b1, 4'h5, 1'b0, 8'h00);
        idle_cycles(4);
        check("holdoff_bits", 32'(obs4[7:0]), 32'h000000A5);
        idle_cycles(1);

        // Reset in the middle of a word, while a 1 is on dout.
        cycle(1'b1, 4'b1100, 1'b0, 8'h00);
        cycle(1'b0, 4'h0, 1'b0, 8'h00);
        v4 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midword_rst_dout", 32'(dout4), 32'h0);
        check("midword_rst_busy", 32'(busy4), 32'h0);
        check("midword_rst_last", 32'(last4), 32'h0);
        check("midword_rst_ready", 32'(rdy4), 32'h1);
        q4 = {};
        q8 = {};
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 4'b1001, 1'b0, 8'h00);
        idle_cycles(4);
        check("after_rst_bits", 32'(obs4[3:0]), 32'h00000009);
        idle_cycles(1);

        // LSB-first, 8-bit word.
        cycle(1'b0, 4'h0, 1'b1, 8'h81);
        idle_cycles(8);
        check("lsb_first_bits", 32'(obs8[7:0]), 32'h00000081);
        idle_cycles(1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 10) < 6, 4'($urandom), ($urandom % 10) < 6, 8'($urandom));
        end
        idle_cycles(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_piso_serializer

`default_nettype wire
